// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the pipelined ALU: the opcode encoding, the bit
// positions inside the 4-bit status-flag vector, and a helper that packs the
// individual flag bits into that vector.
// No ports (package).
// -----------------------------------------------------------------------------
package alu_pkg;

    // Opcode width is fixed by the established instruction set.
    localparam int OPW = 3;

    // Bit positions inside flags[3:0] = {N, Z, C, V}.
    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    typedef enum logic [OPW-1:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_INC  = 3'b010,
        OP_DEC  = 3'b011,
        OP_PASS = 3'b100,
        OP_NOT  = 3'b101,
        OP_OR   = 3'b110,
        OP_AND  = 3'b111
    } alu_op_e;

    // Place each flag at its named index so callers never depend on ordering.
    function automatic logic [3:0] pack_flags(input logic n,
                                              input logic z,
                                              input logic c,
                                              input logic v);
        logic [3:0] f;
        f        = '0;
        f[FLG_N] = n;
        f[FLG_Z] = z;
        f[FLG_C] = c;
        f[FLG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Purely combinational ALU datapath. Computes one of eight operations on two
// WIDTH-bit operands (modulo 2^WIDTH) and derives the N/Z/C/V status flags.
//
// Ports:
//   a       in   WIDTH  operand A
//   b       in   WIDTH  operand B
//   opcode  in   3      operation select (alu_op_e encoding)
//   result  out  WIDTH  operation result
//   flags   out  4      {N, Z, C, V}
// -----------------------------------------------------------------------------
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OPW-1:0]   opcode,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] operand;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             ovf;

    // inc/dec share the adder and subtractor with the constant 1 as the
    // second operand, so carry/borrow and overflow come out the same way.
    always_comb begin
        operand = b;
        if (alu_op_e'(opcode) == OP_INC || alu_op_e'(opcode) == OP_DEC) begin
            operand = {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // One extra bit: sum's top bit is the carry-out, diff's top bit goes high
    // exactly when the unsigned subtraction wraps, i.e. the borrow.
    assign sum  = {1'b0, a} + {1'b0, operand};
    assign diff = {1'b0, a} - {1'b0, operand};

    always_comb begin
        res   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (alu_op_e'(opcode))
            OP_ADD, OP_INC: begin
                res   = sum[MSB:0];
                carry = sum[WIDTH];
                // Same-sign operands producing a different-sign result.
                ovf   = (a[MSB] == operand[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_SUB, OP_DEC: begin
                res   = diff[MSB:0];
                carry = diff[WIDTH];
                // Opposite-sign operands where the result lost A's sign.
                ovf   = (a[MSB] != operand[MSB]) && (diff[MSB] != a[MSB]);
            end
            OP_PASS: res = a;
            OP_NOT:  res = ~a;
            OP_OR:   res = a | b;
            OP_AND:  res = a & b;
            default: res = '0;
        endcase
        result = res;
        flags  = pack_flags(res[MSB], (res == '0), carry, ovf);
    end

endmodule

// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe
// Two-stage pipelined ALU with valid/ready handshakes on both sides.
// Stage 1 captures the operand bundle; stage 2 registers the alu_core result
// and flags. One operation per cycle, two cycles of latency when the consumer
// never stalls; back-pressure from out_ready ripples back to in_ready.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   enable     in   1      when low, no new bundles are accepted
//   in_valid   in   1      operand bundle valid
//   in_ready   out  1      bundle can be accepted this cycle
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   opcode     in   3      operation select
//   out_valid  out  1      result/flags valid
//   out_ready  in   1      consumer takes the result this cycle
//   result     out  WIDTH  operation result
//   flags      out  4      {N, Z, C, V}
// -----------------------------------------------------------------------------
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OPW-1:0]   opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [OPW-1:0]   s1_op;
    logic             s2_valid;

    logic             s1_adv;
    logic             accept;
    logic             s2_load;
    logic [WIDTH-1:0] core_result;
    logic [3:0]       core_flags;

    // Stage 1 may hand its bundle on whenever stage 2 is empty or draining.
    // in_ready depends only on pipeline state and enable, never on in_valid.
    assign s1_adv   = !s2_valid || out_ready;
    assign in_ready = enable && (!s1_valid || s1_adv);
    assign accept   = in_valid && in_ready;
    assign s2_load  = s1_valid && s1_adv;

    // An accept wins over the advance, so back-to-back bundles refill stage 1
    // in the same edge that its previous content moves into stage 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_a     <= a;
            s1_b     <= b;
            s1_op    <= opcode;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a      (s1_a),
        .b      (s1_b),
        .opcode (s1_op),
        .result (core_result),
        .flags  (core_flags)
    );

    // A load takes priority over emptying, so a handshake coinciding with a
    // new result keeps out_valid high. While stalled nothing here changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            result   <= '0;
            flags    <= '0;
        end else if (s2_load) begin
            s2_valid <= 1'b1;
            result   <= core_result;
            flags    <= core_flags;
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

    assign out_valid = s2_valid;

endmodule
